// File: rtl/data_distributor.sv
// data_distributor: demultiplexes a time-multiplexed sample stream into four channel outputs updated a whole frame at a time.
module data_distributor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [1:0]       ch,
  output logic             frame,
  output logic             err
);
  logic [WIDTH-1:0] s0, s1, s2;
  logic             wr0, wr1, wr2, done;
  always_comb begin
    wr0  = en && (sync || ch == 2'd0);
    wr1  = en && !sync && ch == 2'd1;
    wr2  = en && !sync && ch == 2'd2;
    done = en && !sync && ch == 2'd3;
  end
  // the channel-3 sample is loaded straight into q3, so its shadow slot never needs storing
  always_ff @(posedge clk) begin
    if (rst) begin
      s0    <= '0;
      s1    <= '0;
      s2    <= '0;
      q0    <= '0;
      q1    <= '0;
      q2    <= '0;
      q3    <= '0;
      ch    <= '0;
      frame <= 1'b0;
      err   <= 1'b0;
    end else begin
      s0    <= wr0 ? din : s0;
      s1    <= wr1 ? din : s1;
      s2    <= wr2 ? din : s2;
      q0    <= done ? s0 : q0;
      q1    <= done ? s1 : q1;
      q2    <= done ? s2 : q2;
      q3    <= done ? din : q3;
      ch    <= !en ? ch : sync ? 2'd1 : ch + 2'd1;
      frame <= done;
      err   <= err || (en && sync && ch != 2'd0);
    end
  end
endmodule

// File: tb/tb_data_distributor.sv
// tb_data_distributor: directed stimulus with a frame scoreboard checked by an independent monitor.
module tb_data_distributor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] q0, q1, q2, q3;
  logic [1:0] ch;
  logic       frame, err;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] exp_q[$];

  data_distributor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .ch(ch), .frame(frame), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic [7:0] d);
    en = e;
    sync = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ch"}, 32'(ch), 0);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " frame"}, 32'(frame), 0);
    chk({tag, " q"}, {q0, q1, q2, q3}, 0);
  endtask

  always @(negedge clk) begin
    if (frame) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_unexpected: got q=%h expected no frame", {q0, q1, q2, q3});
      end else begin
        chk("frame_q", {q0, q1, q2, q3}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    step(1, 1, 8'hff);
    rst = 1'b0;
    chk_zero("reset");
    // single frame with sync on the first sample
    exp_q.push_back(32'h01000101);
    step(1, 1, 8'h01);
    step(1, 0, 8'h00);
    step(1, 0, 8'h01);
    chk("f1 early frame", 32'(frame), 0);
    step(1, 0, 8'h01);
    chk("f1 frame", 32'(frame), 1);
    chk("f1 ch", 32'(ch), 0);
    chk("f1 err", 32'(err), 0);
    // back-to-back frames
    exp_q.push_back(32'h10111213);
    exp_q.push_back(32'h14151617);
    for (int i = 0; i < 8; i++) begin
      step(1, (i % 4) == 0, 8'(8'h10 + i));
      chk("b2b frame", 32'(frame), 32'((i % 4) == 3));
      chk("b2b ch", 32'(ch), 32'((i + 1) % 4));
    end
    chk("b2b err", 32'(err), 0);
    // gaps in en, including an unqualified sync
    exp_q.push_back(32'ha1b2c3d4);
    step(1, 0, 8'ha1);
    step(0, 0, 8'hee);
    chk("gap frame", 32'(frame), 0);
    chk("gap q", {q0, q1, q2, q3}, 32'h14151617);
    step(0, 1, 8'hee);
    chk("gap ch", 32'(ch), 1);
    chk("gap err", 32'(err), 0);
    step(1, 0, 8'hb2);
    step(0, 0, 8'hee);
    step(1, 0, 8'hc3);
    step(1, 0, 8'hd4);
    chk("gap final frame", 32'(frame), 1);
    // sync ignored without en, then resync error
    step(1, 0, 8'h50);
    step(1, 0, 8'h51);
    step(0, 1, 8'h99);
    chk("idle sync ch", 32'(ch), 2);
    chk("idle sync err", 32'(err), 0);
    chk("idle sync q", {q0, q1, q2, q3}, 32'ha1b2c3d4);
    step(1, 1, 8'h55);
    chk("resync err", 32'(err), 1);
    chk("resync ch", 32'(ch), 1);
    chk("resync frame", 32'(frame), 0);
    exp_q.push_back(32'h55667788);
    step(1, 0, 8'h66);
    step(1, 0, 8'h77);
    step(1, 0, 8'h88);
    chk("resync frame done", 32'(frame), 1);
    chk("resync err sticky", 32'(err), 1);
    // reset mid-frame, with en and sync asserted alongside
    step(1, 0, 8'h01);
    step(1, 0, 8'h02);
    rst = 1'b1;
    step(1, 1, 8'hff);
    rst = 1'b0;
    chk_zero("midreset");
    exp_q.push_back(32'h21222324);
    step(1, 0, 8'h21);
    step(1, 0, 8'h22);
    step(1, 0, 8'h23);
    step(1, 0, 8'h24);
    chk("postreset frame", 32'(frame), 1);
    // sync at channel 3 does not complete a frame
    step(1, 0, 8'h31);
    step(1, 0, 8'h32);
    step(1, 0, 8'h33);
    chk("ch3 ch", 32'(ch), 3);
    step(1, 1, 8'h40);
    chk("ch3 sync frame", 32'(frame), 0);
    chk("ch3 sync ch", 32'(ch), 1);
    chk("ch3 sync err", 32'(err), 1);
    chk("ch3 sync q", {q0, q1, q2, q3}, 32'h21222324);
    exp_q.push_back(32'h40414243);
    step(1, 0, 8'h41);
    step(1, 0, 8'h42);
    step(1, 0, 8'h43);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("frames pending", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_distributor.md
DATA_DISTRIBUTOR -- requirements
Module: data_distributor

Interface
REQ-001 Parameter WIDTH, default 1: bit width of DIN and of each output channel Q0..Q3.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 DIN  input  WIDTH  time-multiplexed data sample.
REQ-005 EN  input  1  sample strobe; DIN is accepted only in cycles with EN=1.
REQ-006 SYNC  input  1  frame marker; when qualified by EN, marks DIN as the channel-0 sample.
REQ-007 Q0, Q1, Q2, Q3  output  WIDTH each  demultiplexed channel outputs, held between frame updates.
REQ-008 CH  output  2  channel index the next accepted sample will be written to.
REQ-009 FRAME  output  1  one-cycle pulse when Q0..Q3 update.
REQ-010 ERR  output  1  sticky resynchronisation error flag.

Function
REQ-011 The block SHALL hold four internal shadow registers S0..S3 of WIDTH bits and a 2-bit channel counter driving CH.
REQ-012 EN=1, SYNC=0: DIN SHALL be written to S[CH], and CH SHALL increment by 1 modulo 4 (3 -> 0).
REQ-013 EN=1, SYNC=1: DIN SHALL be written to S0, and CH SHALL become 1, regardless of the prior CH.
REQ-014 EN=1, SYNC=1 with prior CH != 0: ERR SHALL be set to 1 and stay set until RST.
REQ-015 SYNC with EN=0 SHALL be ignored: no write, no CH change, no ERR change.
REQ-016 EN=0: S0..S3, CH, Q0..Q3 SHALL hold; FRAME SHALL be 0.
REQ-017 An accepted sample written to channel 3 (CH=3, SYNC=0) SHALL complete a frame. On the next rising edge Q0..Q2 SHALL load S0..S2, Q3 SHALL load the DIN just accepted, and FRAME SHALL be 1 for exactly that one cycle.
REQ-018 Q0..Q3 SHALL change only on frame completion. A partial frame SHALL never appear on the outputs.
REQ-019 Latency: Q0..Q3 and FRAME SHALL be valid in the cycle after the clock edge that accepts the channel-3 sample.
REQ-020 Back-to-back frames (EN held high continuously) SHALL produce a FRAME pulse every 4 cycles with no lost samples.
REQ-021 SYNC=1 when CH=3 SHALL not complete a frame: the sample goes to S0, CH becomes 1, ERR is set, and FRAME stays 0. S1..S3 contents SHALL be discarded from the next frame only by being overwritten.
REQ-022 CH SHALL be a registered output reflecting the counter directly. FRAME and ERR SHALL be registered.

Reset
REQ-023 With RST=1 at a rising edge, the following SHALL be 0 in the next cycle: CH, S0..S3, Q0..Q3, FRAME, ERR.
REQ-024 RST SHALL take priority over EN and SYNC in the same cycle.
REQ-025 RST asserted mid-frame SHALL discard the partial frame. The first accepted sample after reset SHALL go to channel 0.

Verification
REQ-026 WIDTH=1; after reset, EN=1, SYNC=1 on the first sample, DIN=1,0,1,1 -> FRAME pulses once; Q0..Q3=1,0,1,1; ERR=0; CH=0.
REQ-027 WIDTH=8; EN continuous, DIN=0x10..0x17, SYNC on 0x10 and 0x14 -> FRAME on cycles 5 and 9; Q=0x10..0x13, then Q=0x14..0x17; ERR=0.
REQ-028 EN=1,0,0,1,0,1,1 with DIN=A,x,x,B,x,C,D -> Q0..Q3=A,B,C,D after the last accepted sample; Q unchanged and FRAME=0 during the gaps.
REQ-029 Two samples, then SYNC with EN=1 on DIN=0x55 -> ERR=1, CH=1, S0=0x55, no FRAME; after three more samples, FRAME with Q0=0x55; ERR remains 1.
REQ-030 RST=1 after two samples of a frame -> all outputs 0 next cycle; a full 4-sample frame without SYNC then outputs exactly those 4 samples.
REQ-031 SYNC=1 with EN=0 at CH=2 -> CH stays 2, ERR stays 0, no register change.
